// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, status bit positions and serializer states for mmio_uart_tx
package mmio_pkg;

  localparam logic [31:0] TX_DATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS  = 32'd4;

  localparam int EMPTY   = 0;
  localparam int FULL    = 1;
  localparam int BUSY    = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - first-word-fall-through synchronous FIFO feeding the serializer
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter; MMIO_UART_TX_PARITY_EN adds an even parity bit
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int          DEPTH        = 4,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);

  logic            sel_data, sel_status, wr_data;
  logic            push, pop, full, empty, overflow;
  logic [7:0]      head;
  logic [CNTW-1:0] count;

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:8];

  assign sel_data   = (dataadr == BASE_ADDR + TX_DATA_OFS);
  assign sel_status = (dataadr == BASE_ADDR + STATUS_OFS);
  assign hit        = sel_data | sel_status;
  assign wr_data    = memwrite & sel_data;
  assign push       = wr_data & ~full;

  tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (writedata[7:0]),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     overflow <= 1'b0;
    else if (wr_data & full)                       overflow <= 1'b1;
    else if (memwrite & sel_status & writedata[3]) overflow <= 1'b0;
  end

  always_comb begin
    readdata = '0;
    if (sel_status) begin
      readdata[CNT_LSB +: 8] = 8'(count);
      readdata[OVF]          = overflow;
      readdata[BUSY]         = tx_busy;
      readdata[FULL]         = full;
      readdata[EMPTY]        = empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tick_d  = '0;
          idx_d   = '0;
`ifdef MMIO_UART_TX_PARITY_EN
          par_d   = even_parity(head);
`endif
          state_d = START;
        end
      end
      START: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx_busy <= (state_q != IDLE);
      case (state_q)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_q[0];
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY:  tx <= par_q;
`endif
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with a frame-level line model
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0080;
  localparam logic [31:0] STAT  = 32'h0000_0084;
  localparam int          DEPTH = 4;
  localparam int          CPB   = 4;

  logic        clk, reset, memwrite;
  logic [31:0] dataadr, writedata, readdata;
  logic        hit, tx, tx_busy;

  int checks   = 0;
  int failures = 0;

  logic rec_en = 1'b0;
  logic rec_tx[$];
  logic rec_busy[$];
  logic exp_tx[$];
  logic exp_busy[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .hit       (hit),
    .readdata  (readdata),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rec_en) begin
      rec_tx.push_back(tx);
      rec_busy.push_back(tx_busy);
    end
  end

  task automatic add_bits(input logic v, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(v);
      exp_busy.push_back(b);
    end
  endtask

  // Line model: 2 idle samples (push edge, pop edge), frames separated by one idle cycle.
  task automatic build_expected(input logic [7:0] bytes[$]);
    exp_tx.delete();
    exp_busy.delete();
    add_bits(1'b1, 1'b0, 2);
    foreach (bytes[i]) begin
      logic [7:0] b;
      b = bytes[i];
      if (i > 0) add_bits(1'b1, 1'b0, 1);
      add_bits(1'b0, 1'b1, CPB);
      for (int j = 0; j < 8; j++) add_bits(b[j], 1'b1, CPB);
`ifdef MMIO_UART_TX_PARITY_EN
      add_bits(^b, 1'b1, CPB);
`endif
      add_bits(1'b1, 1'b1, CPB);
    end
    add_bits(1'b1, 1'b0, 3);
  endtask

  task automatic push_words(input logic [31:0] w[$]);
    @(posedge clk); #1;
    foreach (w[i]) begin
      memwrite  = 1'b1;
      dataadr   = BASE;
      writedata = w[i];
      @(posedge clk); #1;
      if (i == 0) begin
        rec_tx.delete();
        rec_busy.delete();
        rec_en = 1'b1;
      end
    end
    memwrite = 1'b0;
  endtask

  task automatic check_wave(input string name);
    int guard;
    guard = 0;
    while (rec_tx.size() < exp_tx.size() && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    rec_en = 1'b0;
    checks++;
    if (rec_tx.size() < exp_tx.size()) begin
      failures++;
      $display("FAIL %s timeout samples=%0d required=%0d", name, rec_tx.size(), exp_tx.size());
    end else begin
      foreach (exp_tx[k]) begin
        checks++;
        if (rec_tx[k] !== exp_tx[k]) begin
          failures++;
          $display("FAIL %s tx cycle=%0d got=%b expected=%b", name, k, rec_tx[k], exp_tx[k]);
        end
        checks++;
        if (rec_busy[k] !== exp_busy[k]) begin
          failures++;
          $display("FAIL %s tx_busy cycle=%0d got=%b expected=%b", name, k, rec_busy[k], exp_busy[k]);
        end
      end
    end
  endtask

  task automatic read_status(output logic [31:0] v);
    dataadr = STAT;
    #1;
    v = readdata;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'h0;
    writedata = 32'h0;
    #5 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b expected=1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", tx_busy); end
    dataadr = STAT;
    #1;
    checks++;
    if (readdata !== 32'h0000_0001) begin failures++; $display("FAIL reset_status got=%h expected=00000001", readdata); end
    checks++;
    if (hit !== 1'b1) begin failures++; $display("FAIL reset_hit_status got=%b expected=1", hit); end
    dataadr = BASE;
    #1;
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL reset_data_read got=%h expected=00000000", readdata); end
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    logic [31:0] w[$];
    logic [7:0]  q[$];
    logic [31:0] r, st;
    r = $urandom();
    w = {{r[31:8], b}};
    q = {b};
    build_expected(q);
    push_words(w);
    check_wave(name);
    read_status(st);
    checks++;
    if (st !== 32'h0000_0001) begin failures++; $display("FAIL %s_status_after got=%h expected=00000001", name, st); end
  endtask

  task automatic test_burst(input int n, input string name);
    logic [31:0] w[$];
    logic [7:0]  q[$];
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      w.push_back(r);
      q.push_back(r[7:0]);
    end
    build_expected(q);
    push_words(w);
    check_wave(name);
  endtask

  task automatic test_overflow;
    logic [31:0] w[$];
    logic [7:0]  q[$];
    logic [31:0] st;
    w = {32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, 32'h0000_00A4, 32'h0000_00A5, 32'h0000_00A6};
    q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    push_words(w);
    read_status(st);
    checks++;
    if (st !== 32'h0000_040E) begin failures++; $display("FAIL ovf_status got=%h expected=0000040e", st); end
    memwrite  = 1'b1;
    dataadr   = STAT;
    writedata = 32'h8;
    @(posedge clk); #1;
    memwrite = 1'b0;
    read_status(st);
    checks++;
    if (st !== 32'h0000_0406) begin failures++; $display("FAIL ovf_cleared got=%h expected=00000406", st); end
    build_expected(q);
    check_wave("ovf_frames");
    read_status(st);
    checks++;
    if (st !== 32'h0000_0001) begin failures++; $display("FAIL ovf_drained got=%h expected=00000001", st); end
  endtask

  task automatic test_decode;
    logic [31:0] adrs[2];
    logic [31:0] st;
    logic [31:0] w[$];
    logic [7:0]  q[$];
    adrs[0] = 32'h0000_0088;
    adrs[1] = 32'h0000_007C;
    foreach (adrs[i]) begin
      @(posedge clk); #1;
      memwrite  = 1'b1;
      dataadr   = adrs[i];
      writedata = $urandom();
      #1;
      checks++;
      if (hit !== 1'b0) begin failures++; $display("FAIL decode_hit adr=%h got=%b expected=0", adrs[i], hit); end
      checks++;
      if (readdata !== 32'h0) begin failures++; $display("FAIL decode_read adr=%h got=%h expected=0", adrs[i], readdata); end
      @(posedge clk); #1;
      memwrite = 1'b0;
    end
    read_status(st);
    checks++;
    if (st !== 32'h0000_0001) begin failures++; $display("FAIL decode_no_push got=%h expected=00000001", st); end
    memwrite  = 1'b1;
    dataadr   = STAT;
    writedata = 32'h0;
    #1;
    checks++;
    if (readdata !== 32'h0000_0001) begin failures++; $display("FAIL decode_read_during_write got=%h expected=00000001", readdata); end
    @(posedge clk); #1;
    memwrite = 1'b0;
    dataadr  = BASE;
    #1;
    checks++;
    if (hit !== 1'b1) begin failures++; $display("FAIL decode_hit_data got=%b expected=1", hit); end
    w = {32'h0000_01FF};
    q = {8'hFF};
    build_expected(q);
    push_words(w);
    check_wave("decode_1ff");
  endtask

  task automatic test_reset_mid;
    logic [31:0] w[$];
    logic [7:0]  q[$];
    logic [31:0] r, st;
    int          guard;
    r = $urandom();
    r[3] = 1'b0;
    w = {r, $urandom()};
    q = {r[7:0]};
    build_expected(q);
    push_words(w);
    guard = 0;
    while (rec_tx.size() < 2 + 4*CPB + 1 && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (tx !== exp_tx[2 + 4*CPB]) begin failures++; $display("FAIL midreset_bit3 got=%b expected=%b", tx, exp_tx[2 + 4*CPB]); end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b expected=1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b expected=0", tx_busy); end
    read_status(st);
    checks++;
    if (st !== 32'h0000_0001) begin failures++; $display("FAIL midreset_flush got=%h expected=00000001", st); end
    @(posedge clk); #3;
    reset = 1'b0;
    rec_en = 1'b0;
    rec_tx.delete();
    rec_busy.delete();
    exp_tx.delete();
    exp_busy.delete();
    add_bits(1'b1, 1'b0, 60);
    rec_en = 1'b1;
    check_wave("midreset_quiet");
  endtask

  initial begin
    test_reset();
    test_single(8'h55, "single_55");
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r;
      r = $urandom();
      test_single(r[7:0], "single_rand");
    end
    test_overflow();
    test_decode();
    for (int i = 0; i < 2; i++) test_burst($urandom_range(2, DEPTH + 1), "burst_rand");
`ifdef MMIO_UART_TX_PARITY_EN
    test_single(8'h07, "parity_07");
    test_single(8'h03, "parity_03");
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
